// File: rtl/multdiv_controller.sv
// Sequencer for the shared multi-cycle multdiv unit: operand latch, start pulse, stall, regfile write arbitration.
// Optional watchdog on the BUSY wait is enabled by defining MULTDIV_TIMEOUT_EN.
module multdiv_controller #(
    parameter int unsigned MULT_STATUS    = 4,
    parameter int unsigned DIV_STATUS     = 5,
    parameter int unsigned STATUS_REG     = 30,
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned TIMEOUT_STATUS = 6
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        issue_valid,
    input  logic        issue_is_div,
    input  logic [4:0]  issue_rd,
    input  logic [31:0] issue_a,
    input  logic [31:0] issue_b,
    output logic [31:0] md_a,
    output logic [31:0] md_b,
    output logic        md_mult,
    output logic        md_div,
    input  logic        md_ready,
    input  logic        md_exception,
    input  logic [31:0] md_result,
    input  logic        w_we,
    input  logic [4:0]  w_reg,
    input  logic [31:0] w_data,
    output logic        rf_we,
    output logic [4:0]  rf_reg,
    output logic [31:0] rf_data,
    output logic        stall,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, START, BUSY, WB} state_t;

    state_t      state, state_n;
    logic [4:0]  rd_q;
    logic        is_div_q;
    logic        exc_q;
    logic        timeout_q;
    logic [31:0] result_q;
    logic        timeout_hit;

`ifdef MULTDIV_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] wdog;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wdog <= '0;
        end else if (state == START) begin
            wdog <= '0;
        end else if (state == BUSY) begin
            wdog <= wdog + 1'b1;
        end
    end

    // The hit lands on the last of TIMEOUT_CYCLES BUSY cycles so WB follows exactly that many.
    assign timeout_hit = (state == BUSY) && !md_ready && (wdog == CW'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0 && (TIMEOUT_CYCLES != 0);
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            md_a      <= '0;
            md_b      <= '0;
            rd_q      <= '0;
            is_div_q  <= 1'b0;
            exc_q     <= 1'b0;
            timeout_q <= 1'b0;
            result_q  <= '0;
        end else begin
            state <= state_n;
            if (state == IDLE && issue_valid) begin
                md_a      <= issue_a;
                md_b      <= issue_b;
                rd_q      <= issue_rd;
                is_div_q  <= issue_is_div;
                exc_q     <= 1'b0;
                timeout_q <= 1'b0;
            end
            if (state == BUSY) begin
                if (md_ready) begin
                    result_q <= md_result;
                    exc_q    <= md_exception;
                end else if (timeout_hit) begin
                    exc_q     <= 1'b1;
                    timeout_q <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_n = state;
        md_mult = 1'b0;
        md_div  = 1'b0;
        rf_we   = w_we;
        rf_reg  = w_reg;
        rf_data = w_data;
        unique case (state)
            IDLE:  if (issue_valid) state_n = START;
            START: begin
                md_mult = !is_div_q;
                md_div  = is_div_q;
                state_n = BUSY;
            end
            BUSY:  if (md_ready || timeout_hit) state_n = WB;
            WB: begin
                if (!w_we) begin
                    state_n = IDLE;
                    if (exc_q) begin
                        rf_we  = 1'b1;
                        rf_reg = 5'(STATUS_REG);
                        if (timeout_q)     rf_data = 32'(TIMEOUT_STATUS);
                        else if (is_div_q) rf_data = 32'(DIV_STATUS);
                        else               rf_data = 32'(MULT_STATUS);
                    end else if (rd_q != '0) begin
                        rf_we   = 1'b1;
                        rf_reg  = rd_q;
                        rf_data = result_q;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign busy  = (state != IDLE);
    assign stall = issue_valid | busy;

endmodule

// File: tb/tb_multdiv_controller.sv
// Vector table of mult/div transactions plus hand sequences for reset, START-ready and watchdog cases.
// Controller regfile writes are checked against a queue filled when each result is handed to the DUT.
module tb_multdiv_controller;

`ifdef MULTDIV_TIMEOUT_EN
    localparam int unsigned TB_TIMEOUT = 8;
`else
    localparam int unsigned TB_TIMEOUT = 64;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        issue_valid = 1'b0, issue_is_div = 1'b0;
    logic [4:0]  issue_rd = '0;
    logic [31:0] issue_a = '0, issue_b = '0;
    logic [31:0] md_a, md_b;
    logic        md_mult, md_div;
    logic        md_ready = 1'b0, md_exception = 1'b0;
    logic [31:0] md_result = '0;
    logic        w_we = 1'b0;
    logic [4:0]  w_reg = '0;
    logic [31:0] w_data = '0;
    logic        rf_we;
    logic [4:0]  rf_reg;
    logic [31:0] rf_data;
    logic        stall, busy;

    multdiv_controller #(.TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
        .clock(clock), .reset(reset),
        .issue_valid(issue_valid), .issue_is_div(issue_is_div), .issue_rd(issue_rd),
        .issue_a(issue_a), .issue_b(issue_b),
        .md_a(md_a), .md_b(md_b), .md_mult(md_mult), .md_div(md_div),
        .md_ready(md_ready), .md_exception(md_exception), .md_result(md_result),
        .w_we(w_we), .w_reg(w_reg), .w_data(w_data),
        .rf_we(rf_we), .rf_reg(rf_reg), .rf_data(rf_data),
        .stall(stall), .busy(busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        is_div;
        logic [4:0]  rd;
        logic [31:0] a, b;
        int unsigned delay;
        logic        exc;
        logic [31:0] res;
        int unsigned wbusy;
        logic        stray;
        logic        rstart;
        logic        exp_we;
        logic [4:0]  exp_reg;
        logic [31:0] exp_data;
    } vec_t;

    typedef struct {
        logic [4:0]  rreg;
        logic [31:0] data;
    } exp_t;

    exp_t        sb[$];
    int unsigned checks = 0;
    int unsigned errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    always @(negedge clock) begin
        if (reset) begin
            if (w_we) begin
                chk("w_pass_we", 32'(rf_we), 32'd1);
                chk("w_pass_reg", 32'(rf_reg), 32'(w_reg));
                chk("w_pass_data", rf_data, w_data);
            end else if (rf_we) begin
                if (sb.size() == 0) begin
                    chk("unexpected_write", 32'(rf_reg), 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("ctrl_reg", 32'(rf_reg), 32'(e.rreg));
                    chk("ctrl_data", rf_data, e.data);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic issue(input logic is_div, input logic [4:0] rd, input logic [31:0] a, input logic [31:0] b);
        tick();
        issue_valid = 1'b1; issue_is_div = is_div; issue_rd = rd; issue_a = a; issue_b = b;
        #1;
        chk("stall_on_issue", 32'(stall), 32'd1);
        chk("idle_before", 32'(busy), 32'd0);
    endtask

    task automatic run_op(input vec_t v);
        issue(v.is_div, v.rd, v.a, v.b);
        tick();
        issue_valid = 1'b0;
        if (v.rstart) begin
            md_ready = 1'b1; md_exception = 1'b0; md_result = ~v.res;
        end
        #1;
        chk("start_mult", 32'(md_mult), 32'(!v.is_div));
        chk("start_div", 32'(md_div), 32'(v.is_div));
        chk("md_a", md_a, v.a);
        chk("md_b", md_b, v.b);
        tick();
        md_ready = 1'b0;
        #1;
        chk("pulse_once", 32'(md_mult | md_div), 32'd0);
        for (int unsigned i = 1; i < v.delay; i++) begin
            if (v.stray && i == 1) begin
                issue_valid = 1'b1; issue_a = 32'hDEAD_BEEF; issue_b = 32'h1234_5678;
            end
            tick();
            issue_valid = 1'b0;
        end
        md_ready = 1'b1; md_exception = v.exc; md_result = v.res;
        tick();
        md_ready = 1'b0; md_exception = 1'b0;
        if (v.exp_we) sb.push_back('{rreg: v.exp_reg, data: v.exp_data});
        chk("operand_hold", md_a, v.a);
        for (int unsigned i = 0; i < v.wbusy; i++) begin
            w_we = 1'b1; w_reg = 5'd2; w_data = 32'd9;
            tick();
            chk("hold_in_wb", 32'(busy), 32'd1);
        end
        w_we = 1'b0;
        tick();
        chk("idle_after", 32'(busy), 32'd0);
        chk("stall_drop", 32'(stall), 32'd0);
        chk("write_done", sb.size(), 32'd0);
    endtask

    vec_t vecs[7];

    initial begin
        #1_000_000;
        $display("FAIL time_limit actual=running required=finished");
        $fatal(1, "time limit");
    end

    initial begin
        vecs[0] = '{1'b0, 5'd5,  32'd6,   32'd7, 10, 1'b0, 32'd42,        0, 1'b0, 1'b0, 1'b1, 5'd5,  32'd42};
        vecs[1] = '{1'b1, 5'd9,  32'd100, 32'd0, 4,  1'b1, 32'h0BAD,      0, 1'b0, 1'b0, 1'b1, 5'd30, 32'd5};
        vecs[2] = '{1'b0, 5'd12, 32'd3,   32'd3, 2,  1'b0, 32'd9,         3, 1'b0, 1'b0, 1'b1, 5'd12, 32'd9};
        vecs[3] = '{1'b0, 5'd0,  32'd7,   32'd11, 1, 1'b0, 32'd77,        0, 1'b0, 1'b0, 1'b0, 5'd0,  32'd0};
        vecs[4] = '{1'b1, 5'd31, 32'd84,  32'd2, 1,  1'b0, 32'd42,        1, 1'b0, 1'b1, 1'b1, 5'd31, 32'd42};
        vecs[5] = '{1'b0, 5'd0,  32'h7FFF_FFFF, 32'd2, 3, 1'b1, 32'd0,    0, 1'b1, 1'b0, 1'b1, 5'd30, 32'd4};
        vecs[6] = '{1'b1, 5'd1,  32'd1,   32'd1, 5,  1'b0, 32'hFFFF_FFFF, 2, 1'b1, 1'b1, 1'b1, 5'd1,  32'hFFFF_FFFF};

        // Reset state
        #3;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_md_a", md_a, 32'd0);
        chk("rst_md_b", md_b, 32'd0);
        chk("rst_pulse", 32'(md_mult | md_div), 32'd0);
        chk("rst_stall_lo", 32'(stall), 32'd0);
        issue_valid = 1'b1;
        #1;
        chk("rst_stall_hi", 32'(stall), 32'd1);
        issue_valid = 1'b0;
        w_we = 1'b1; w_reg = 5'd3; w_data = 32'h55AA;
        #1;
        chk("rst_rf_we", 32'(rf_we), 32'd1);
        chk("rst_rf_reg", 32'(rf_reg), 32'd3);
        chk("rst_rf_data", rf_data, 32'h55AA);
        w_we = 1'b0;
        tick();
        reset = 1'b1;

        foreach (vecs[i]) run_op(vecs[i]);

        // Reset during BUSY discards the operation
        issue(1'b0, 5'd4, 32'd11, 32'd13);
        tick();
        issue_valid = 1'b0;
        tick();
        tick();
        #2;
        reset = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_stall", 32'(stall), 32'd0);
        chk("mid_rst_md_a", md_a, 32'd0);
        chk("mid_rst_pulse", 32'(md_mult | md_div), 32'd0);
        chk("mid_rst_rf_we", 32'(rf_we), 32'd0);
        tick();
        reset = 1'b1;
        md_ready = 1'b1; md_result = 32'd55;
        tick();
        md_ready = 1'b0;
        repeat (3) tick();
        chk("late_ready_idle", 32'(busy), 32'd0);

        // Watchdog
        issue(1'b0, 5'd7, 32'd2, 32'd3);
        tick();
        issue_valid = 1'b0;
        tick();
`ifdef MULTDIV_TIMEOUT_EN
        begin
            int unsigned n;
            n = 0;
            sb.push_back('{rreg: 5'd30, data: 32'd6});
            while (busy && n < 20) begin
                tick();
                n++;
            end
            chk("timeout_edges", n, 32'd9);
            chk("timeout_write", sb.size(), 32'd0);
        end
`else
        repeat (20) tick();
        chk("no_timeout_busy", 32'(busy), 32'd1);
        md_ready = 1'b1; md_result = 32'd99;
        tick();
        md_ready = 1'b0;
        sb.push_back('{rreg: 5'd7, data: 32'd99});
        tick();
        chk("late_result_idle", 32'(busy), 32'd0);
        chk("late_result_write", sb.size(), 32'd0);
`endif

        repeat (2) tick();
        chk("sb_empty", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
